sdiv_seq: RTL and testbench

SDIV_SEQ -- requirements
Module: sdiv_seq

---
 rtl/arith_pkg.sv | 22 ++
 rtl/sdiv_step.sv | 24 ++
 rtl/sdiv_seq.sv | 166 ++++++++++++++++
 tb/tb_sdiv_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encoding and the dividend width rule
// used by the sequential divider and the multiplier.
package arith_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_CALC = 2'd1;
  localparam logic [1:0] ENC_FIX  = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_CALC = ENC_CALC,
    ST_FIX  = ENC_FIX,
    ST_DONE = ENC_DONE
  } state_t;

  // Double-width operand (dividend, product) for an N-bit datapath.
  function automatic int dbl_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring division step on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module sdiv_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] dvs_mag,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0]   trial;
  logic [N-1:0] diff;

  // rem_in < dvs_mag on entry, so a successful difference always fits in N bits.
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial[N-1:0] - dvs_mag;
    q_bit   = (trial >= {1'b0, dvs_mag});
    rem_out = q_bit ? diff : trial[N-1:0];
  end

endmodule

// File: rtl/sdiv_seq.sv
// Sequential signed divider, 2N-bit dividend by N-bit divisor, truncating toward zero.
// Define SDIV_OVF_EARLY_EN to add the capture-time quotient overflow exit.
module sdiv_seq
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [dbl_width(N)-1:0] dvd,
  input  logic [N-1:0]            dvs,
  output logic [N-1:0]            quo,
  output logic [N-1:0]            rem,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    dbz
);

  localparam int M  = dbl_width(N);
  localparam int CW = $clog2(N + 1);

  state_t         state, nxt_state;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   r_mag, d_lo, q_mag, dvs_mag;
  logic           neg_q, neg_r;

  logic signed [M:0] dvd_ext, dvd_abs;
  logic [N-1:0]   dvs_abs;
  logic           dvs_zero, early_ovf, unused_msb;

  logic [N-1:0]   step_rem;
  logic           step_q;

  logic           capture, step_en;
  logic [N-1:0]   nxt_quo, nxt_rem;
  logic           nxt_ovf, nxt_dbz;

  // Sign application on an N-bit magnitude.
  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Saturation check: positive results top out at 2^(N-1)-1, negative at 2^(N-1).
  function automatic logic q_overflow(input logic [N-1:0] mag, input logic neg);
    logic [N-1:0] lim;
    lim = {1'b1, {(N-1){1'b0}}};
    if (!neg) lim = lim - 1'b1;
    return mag > lim;
  endfunction

  // Capture-side magnitudes; the extra dividend bit keeps -2^(M-1) from wrapping.
  always_comb begin
    dvd_ext    = {dvd[M-1], dvd};
    dvd_abs    = dvd_ext[M] ? -dvd_ext : dvd_ext;
    dvs_abs    = dvs[N-1] ? (~dvs + 1'b1) : dvs;
    dvs_zero   = (dvs == '0);
    unused_msb = dvd_abs[M];
`ifdef SDIV_OVF_EARLY_EN
    early_ovf  = (dvd_abs[M-1:N] >= dvs_abs);
`else
    early_ovf  = 1'b0;
`endif
  end

  sdiv_step #(.N(N)) u_step (
    .rem_in  (r_mag),
    .bit_in  (d_lo[N-1]),
    .dvs_mag (dvs_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    nxt_state = state;
    nxt_quo   = quo;
    nxt_rem   = rem;
    nxt_ovf   = ovf;
    nxt_dbz   = dbz;
    capture   = 1'b0;
    step_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (dvs_zero) begin
            nxt_state = ST_DONE;
            nxt_quo   = '0;
            nxt_rem   = '0;
            nxt_ovf   = 1'b0;
            nxt_dbz   = 1'b1;
          end else if (early_ovf) begin
            nxt_state = ST_DONE;
            nxt_quo   = '0;
            nxt_rem   = '0;
            nxt_ovf   = 1'b1;
            nxt_dbz   = 1'b0;
          end else begin
            nxt_state = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        step_en = 1'b1;
        if (cnt == CW'(N - 1)) nxt_state = ST_FIX;
      end
      ST_FIX: begin
        nxt_state = ST_DONE;
        nxt_dbz   = 1'b0;
        if (q_overflow(q_mag, neg_q)) begin
          nxt_ovf = 1'b1;
          nxt_quo = '0;
          nxt_rem = '0;
        end else begin
          nxt_ovf = 1'b0;
          nxt_quo = apply_sign(q_mag, neg_q);
          nxt_rem = apply_sign(r_mag, neg_r);
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CALC) || (state == ST_FIX);
  assign done = (state == ST_DONE);

  // Control and visible results: cleared by reset, results only move on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= nxt_state;
      if (capture)      cnt <= '0;
      else if (step_en) cnt <= cnt + 1'b1;
      quo <= nxt_quo;
      rem <= nxt_rem;
      ovf <= nxt_ovf;
      dbz <= nxt_dbz;
    end
  end

  // Magnitude datapath: partial remainder, remaining dividend bits, quotient bits.
  always_ff @(posedge clk) begin
    if (capture) begin
      r_mag   <= dvd_abs[M-1:N];
      d_lo    <= dvd_abs[N-1:0];
      q_mag   <= '0;
      dvs_mag <= dvs_abs;
      neg_r   <= dvd[M-1];
      neg_q   <= dvd[M-1] ^ dvs[N-1];
    end else if (step_en) begin
      r_mag <= step_rem;
      d_lo  <= {d_lo[N-2:0], 1'b0};
      q_mag <= {q_mag[N-2:0], step_q};
    end
  end

endmodule

// File: tb/tb_sdiv_seq.sv
// Directed bench for sdiv_seq (N=4): vector table plus reset-abort and held-start sequences.
module tb_sdiv_seq;

  localparam int N = 4;
  localparam int M = 2 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [M-1:0] dvd = '0;
  logic [N-1:0] dvs = '0;
  logic [N-1:0] quo, rem;
  logic         busy, done, ovf, dbz;

  int total = 0;
  int bad   = 0;

  sdiv_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .quo   (quo),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [M-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic         ovf;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for done after the capture edge; returns edges counted past edge 0.
  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    dvd   = v.dvd;
    dvs   = v.dvs;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dvd   = M'($urandom);
    dvs   = N'($urandom);
    wait_done(k);
    chk({v.name, ".lat"}, k, v.lat);
    chk({v.name, ".quo"}, quo, v.quo);
    chk({v.name, ".rem"}, rem, v.rem);
    chk({v.name, ".ovf"}, ovf, v.ovf);
    chk({v.name, ".dbz"}, dbz, v.dbz);
    @(posedge clk); #1;
    chk({v.name, ".done_pulse"}, done, 1'b0);
    chk({v.name, ".quo_hold"}, quo, v.quo);
  endtask

  initial begin
    int k, n;

    vecs.push_back('{"p45_7",   8'h2D, 4'h7, 4'h6, 4'h3, 1'b0, 1'b0, 5});
    vecs.push_back('{"n9_2",    8'hF7, 4'h2, 4'hC, 4'hF, 1'b0, 1'b0, 5});
    vecs.push_back('{"n21_n3",  8'hEB, 4'hD, 4'h7, 4'h0, 1'b0, 1'b0, 5});
    vecs.push_back('{"n16_2",   8'hF0, 4'h2, 4'h8, 4'h0, 1'b0, 1'b0, 5});
    vecs.push_back('{"p16_2",   8'h10, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0, 5});
    vecs.push_back('{"n56_7",   8'hC8, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0, 5});
    vecs.push_back('{"p7_n2",   8'h07, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, 5});
    vecs.push_back('{"n1_3",    8'hFF, 4'h3, 4'h0, 4'hF, 1'b0, 1'b0, 5});
    vecs.push_back('{"p63_7",   8'h3F, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0, 5});
    vecs.push_back('{"n57_n8",  8'hC7, 4'h8, 4'h7, 4'hF, 1'b0, 1'b0, 5});
    vecs.push_back('{"zero_5",  8'h00, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 5});
    vecs.push_back('{"dbz_45",  8'h2D, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 0});
    vecs.push_back('{"dbz_min", 8'h80, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 0});
`ifdef SDIV_OVF_EARLY_EN
    vecs.push_back('{"early64", 8'h40, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0, 0});
    vecs.push_back('{"earlymin",8'h80, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 0});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst.quo",  quo,  '0);
    chk("rst.rem",  rem,  '0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.ovf",  ovf,  1'b0);
    chk("rst.dbz",  dbz,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Reset mid-CALC after a result is already on the outputs.
    run_vec(vecs[0]);
    @(negedge clk);
    dvd   = 8'hF7;
    dvs   = 4'h2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.quo",  quo,  '0);
    chk("abort.rem",  rem,  '0);
    chk("abort.ovf",  ovf,  1'b0);
    chk("abort.dbz",  dbz,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(10, n);
    chk("abort.no_done", n, 0);

    // Start held through the whole operation: one result, inputs changed after capture.
    @(negedge clk);
    dvd   = 8'hF7;
    dvs   = 4'h2;
    start = 1'b1;
    @(posedge clk); #1;
    dvd = 8'h2D;
    dvs = 4'h7;
    chk("held.busy", busy, 1'b1);
    wait_done(k);
    start = 1'b0;
    chk("held.lat", k, 5);
    chk("held.quo", quo, 4'hC);
    chk("held.rem", rem, 4'hF);
    count_dones(10, n);
    chk("held.one_op", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
